// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters take turns on one ALU_generalizado.
// A request is granted in IDLE, its operands are registered, the ALU is
// evaluated in EXEC, and the result is held in RESP until the consumer takes
// it.
// Optional feature: define ALU_ARB_ROUNDROBIN_EN to break ties in favour of
// the requester that did not win last time. When the macro is left undefined,
// requester 0 always wins a tie.

// Shared ALU. The 3-bit operation codes are:
//   000 add, 001 sub, 010 and, 011 or, 100 xor,
//   101 shift left by b[log2(n_bits)-1:0], 110 logical shift right, 111 no-op.
// The overflow flag reports two's-complement overflow of add and sub.
module ALU_generalizado #(
    parameter int n_bits = 16
) (
    input  logic [n_bits-1:0] a_i,
    input  logic [n_bits-1:0] b_i,
    input  logic [2:0]        op_i,
    output logic [n_bits-1:0] result_o,
    output logic              overflow_o
);
    localparam int SH_W = (n_bits > 1) ? $clog2(n_bits) : 1;

    logic [n_bits-1:0] sum;
    logic [n_bits-1:0] diff;
    logic [SH_W-1:0]   sh;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign sh   = b_i[SH_W-1:0];

    // Operation decode; overflow is derived from the operand and result sign bits.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        result_o   = '0;
        overflow_o = 1'b0;
        case (op_i)
            3'b000: begin
                result_o   = sum;
                overflow_o = (a_i[n_bits-1] == b_i[n_bits-1]) && (sum[n_bits-1] != a_i[n_bits-1]);
            end
            3'b001: begin
                result_o   = diff;
                overflow_o = (a_i[n_bits-1] != b_i[n_bits-1]) && (diff[n_bits-1] != a_i[n_bits-1]);
            end
            3'b010:  result_o = a_i & b_i;
            3'b011:  result_o = a_i | b_i;
            3'b100:  result_o = a_i ^ b_i;
            3'b101:  result_o = a_i << sh;
            3'b110:  result_o = a_i >> sh;
            default: result_o = '0;
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter int N_BITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [N_BITS-1:0] req0_a,
    input  logic [N_BITS-1:0] req0_b,
    input  logic [N_BITS-1:0] req1_a,
    input  logic [N_BITS-1:0] req1_b,
    input  logic [2:0]        req0_op,
    input  logic [2:0]        req1_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [N_BITS-1:0] resp_result,
    output logic              resp_overflow,
    output logic              resp_error,
    output logic              busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [2:0] OP_NOP = 3'b111;

`ifdef ALU_ARB_ROUNDROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_e            state_q;
    logic [N_BITS-1:0] a_q;
    logic [N_BITS-1:0] b_q;
    logic [2:0]        op_q;
    logic              id_q;
    logic              last_grant_q;
    logic              resp_valid_q;
    logic              resp_id_q;
    logic [N_BITS-1:0] resp_result_q;
    logic              resp_overflow_q;
    logic              resp_error_q;
    logic              busy_q;

    logic              accept;
    logic              grant_d;
    logic [N_BITS-1:0] a_d;
    logic [N_BITS-1:0] b_d;
    logic [2:0]        op_d;
    logic [N_BITS-1:0] alu_result;
    logic              alu_overflow;

    // The ALU only ever sees registered operands, so neither front end drives it directly.
    ALU_generalizado #(
        .n_bits(N_BITS)
    ) u_alu (
        .a_i       (a_q),
        .b_i       (b_q),
        .op_i      (op_q),
        .result_o  (alu_result),
        .overflow_o(alu_overflow)
    );

    assign accept = (state_q == S_IDLE) && (req_valid != 2'b00);

    // Winner selection: a lone requester wins outright; a tie goes to 0 or alternates.
    always_comb begin
        grant_d = 1'b0;
        if (req_valid == 2'b11) begin
            grant_d = RR_EN ? ~last_grant_q : 1'b0;
        end else if (req_valid[1]) begin
            grant_d = 1'b1;
        end
    end

    // Grant strobe and operand mux for the selected requester.
    always_comb begin
        req_ready = 2'b00;
        if (accept) begin
            req_ready = grant_d ? 2'b10 : 2'b01;
        end
        a_d  = grant_d ? req1_a  : req0_a;
        b_d  = grant_d ? req1_b  : req0_b;
        op_d = grant_d ? req1_op : req0_op;
    end

    // Control FSM together with the operand and response registers.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q         <= S_IDLE;
            a_q             <= '0;
            b_q             <= '0;
            op_q            <= OP_NOP;
            id_q            <= 1'b0;
            last_grant_q    <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= 1'b0;
            resp_result_q   <= '0;
            resp_overflow_q <= 1'b0;
            resp_error_q    <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q          <= a_d;
                        b_q          <= b_d;
                        op_q         <= op_d;
                        id_q         <= grant_d;
                        last_grant_q <= grant_d;
                        busy_q       <= 1'b1;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                    if (op_q == OP_NOP) begin
                        resp_result_q   <= '0;
                        resp_overflow_q <= 1'b0;
                        resp_error_q    <= 1'b1;
                    end else begin
                        resp_result_q   <= alu_result;
                        resp_overflow_q <= alu_overflow;
                        resp_error_q    <= 1'b0;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    // Invariant: the last grant always names the owner of the request in flight.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_EXEC) begin
            assert (last_grant_q == id_q);
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_result   = resp_result_q;
    assign resp_overflow = resp_overflow_q;
    assign resp_error    = resp_error_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter. A reference model predicts each
// grant from the arbitration rules and pushes the expected response into a
// scoreboard. A separate monitor compares that response against whatever the
// DUT presents. The bench honours ALU_ARB_ROUNDROBIN_EN in the same way the
// design does.
module tb_alu_share_arbiter;
    localparam int W     = 16;
    localparam int S_MAX = (1 << (W - 1)) - 1;
    localparam int S_MIN = -(1 << (W - 1));

`ifdef ALU_ARB_ROUNDROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
    } req_t;

    typedef struct {
        logic         id;
        logic [W-1:0] result;
        logic         ovf;
        logic         err;
        int           acc_cyc;
    } exp_t;

    typedef enum {RDY_ONE, RDY_RANDOM, RDY_BACKPRESSURE} rdy_mode_e;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         resp_valid, resp_ready, resp_id;
    logic [W-1:0] resp_result;
    logic         resp_overflow, resp_error, busy;

    req_t      cur0, cur1;
    req_t      pend0[$];
    req_t      pend1[$];
    exp_t      sb[$];
    logic      id_log[$];
    int        cyc = 0;
    bit        chk_en = 1'b0;
    bit        model_free = 1'b1;
    logic      model_last = 1'b1;
    bit        after_rst = 1'b1;
    int        n_checks = 0;
    int        n_errors = 0;
    int        arrive_pct = 100;
    rdy_mode_e rdy_mode = RDY_ONE;
    int        bp_cnt = 0;
    logic [1:0] last_granted = 2'b00;

    always #5 clk = ~clk;

    assign req0_a  = cur0.a;
    assign req0_b  = cur0.b;
    assign req0_op = cur0.op;
    assign req1_a  = cur1.a;
    assign req1_b  = cur1.b;
    assign req1_op = cur1.op;

    alu_share_arbiter #(.N_BITS(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req0_op      (req0_op),
        .req1_op      (req1_op),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_result  (resp_result),
        .resp_overflow(resp_overflow),
        .resp_error   (resp_error),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected ALU behaviour, computed from signed integer arithmetic.
    task automatic ref_alu(input req_t r, output logic [W-1:0] res, output logic ovf, output logic err);
        int sa, sb_v, s, sh;
        sa   = int'($signed(r.a));
        sb_v = int'($signed(r.b));
        sh   = int'(r.b) % W;
        res  = '0;
        ovf  = 1'b0;
        err  = 1'b0;
        case (r.op)
            3'd0: begin s = sa + sb_v; res = W'(s); ovf = (s > S_MAX) || (s < S_MIN); end
            3'd1: begin s = sa - sb_v; res = W'(s); ovf = (s > S_MAX) || (s < S_MIN); end
            3'd2: res = r.a & r.b;
            3'd3: res = r.a | r.b;
            3'd4: res = r.a ^ r.b;
            3'd5: res = r.a << sh;
            3'd6: res = r.a >> sh;
            default: err = 1'b1;
        endcase
    endtask

    // A lone requester wins; on a tie requester 0 wins unless alternation is enabled.
    function automatic logic pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return RR_EN & ~last;
        return v[1];
    endfunction

    // Reference model: predicts req_ready each cycle and queues the expected response.
    initial begin : model
        logic [1:0]   exp_ready;
        logic         g;
        req_t         r;
        exp_t         e;
        logic [W-1:0] res;
        logic         ovf, err;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cyc++;
                exp_ready = 2'b00;
                g = 1'b0;
                if (model_free && req_valid != 2'b00) begin
                    g = pick(req_valid, model_last);
                    exp_ready = g ? 2'b10 : 2'b01;
                end
                check("req_ready", 32'(req_ready), 32'(exp_ready));
                if (exp_ready != 2'b00) begin
                    r = g ? cur1 : cur0;
                    ref_alu(r, res, ovf, err);
                    e.id      = g;
                    e.result  = res;
                    e.ovf     = ovf;
                    e.err     = err;
                    e.acc_cyc = cyc;
                    sb.push_back(e);
                    model_free = 1'b0;
                    model_last = g;
                end
            end
        end
    end

    // Monitor: checks response timing and contents, and retires on handshake.
    initial begin : monitor
        exp_t e;
        bit   have, exp_valid, exp_busy;
        forever begin
            @(negedge clk);
            #2;
            if (chk_en) begin
                have      = sb.size() > 0;
                e         = have ? sb[0] : e;
                exp_valid = have && (cyc >= e.acc_cyc + 2);
                exp_busy  = have && (cyc > e.acc_cyc);
                check("resp_valid", 32'(resp_valid), 32'(exp_valid));
                check("busy", 32'(busy), 32'(exp_busy));
                if (resp_valid && have) begin
                    check("resp_id", 32'(resp_id), 32'(e.id));
                    check("resp_result", 32'(resp_result), 32'(e.result));
                    check("resp_overflow", 32'(resp_overflow), 32'(e.ovf));
                    check("resp_error", 32'(resp_error), 32'(e.err));
                end
                if (exp_valid) after_rst = 1'b0;
                if (after_rst) begin
                    check("rst_resp_id", 32'(resp_id), 32'd0);
                    check("rst_resp_result", 32'(resp_result), 32'd0);
                    check("rst_resp_flags", 32'({resp_overflow, resp_error}), 32'd0);
                end
                if (rst) begin
                    sb.delete();
                    model_free = 1'b1;
                    model_last = 1'b1;
                    after_rst  = 1'b1;
                end else if (resp_valid && resp_ready && have) begin
                    id_log.push_back(e.id);
                    void'(sb.pop_front());
                    model_free = 1'b1;
                end
            end
        end
    end

    // One driver cycle: observe grants, then update requests and resp_ready after the edge.
    task automatic step();
        logic [1:0] granted;
        @(negedge clk);
        granted = req_ready;
        if (resp_valid) bp_cnt++;
        else bp_cnt = 0;
        @(posedge clk);
        #1;
        last_granted = granted;
        if (req_valid[0] && granted[0]) req_valid[0] = 1'b0;
        if (req_valid[1] && granted[1]) req_valid[1] = 1'b0;
        if (!req_valid[0] && pend0.size() > 0 && int'($urandom_range(99)) < arrive_pct) begin
            cur0 = pend0.pop_front();
            req_valid[0] = 1'b1;
        end
        if (!req_valid[1] && pend1.size() > 0 && int'($urandom_range(99)) < arrive_pct) begin
            cur1 = pend1.pop_front();
            req_valid[1] = 1'b1;
        end
        case (rdy_mode)
            RDY_ONE:          resp_ready = 1'b1;
            RDY_RANDOM:       resp_ready = 1'($urandom_range(1));
            default:          resp_ready = (bp_cnt >= 5);
        endcase
    endtask

    task automatic drain(input string name, input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = pend0.size() == 0 && pend1.size() == 0 && req_valid == 2'b00 && sb.size() == 0;
        end
        check({name, "_drained"}, 32'(done), 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic req_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        req_t r;
        r.a  = a;
        r.b  = b;
        r.op = op;
        return r;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic tie_seq[4];
        int   base, n;
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        cur0       = mk('0, '0, 3'b111);
        cur1       = mk('0, '0, 3'b111);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Single request straight after reset.
        rdy_mode   = RDY_ONE;
        arrive_pct = 100;
        pend0.push_back(mk(16'h0003, 16'h0004, 3'b000));
        drain("single", 50);

        // Both requesters held for four transactions each from a fresh reset.
        pulse_reset();
        base = id_log.size();
        for (int i = 0; i < 4; i++) begin
            pend0.push_back(mk(W'($urandom), W'($urandom), 3'($urandom_range(6))));
            pend1.push_back(mk(W'($urandom), W'($urandom), 3'($urandom_range(6))));
        end
        drain("tie", 100);
        tie_seq = RR_EN ? '{1'b0, 1'b1, 1'b0, 1'b1} : '{1'b0, 1'b0, 1'b0, 1'b0};
        check("tie_count", 32'(id_log.size() - base), 32'd8);
        for (int k = 0; k < 4; k++) begin
            if (id_log.size() > base + k) check("tie_order", 32'(id_log[base + k]), 32'(tie_seq[k]));
            else check("tie_order_missing", 32'(k), 32'(-1));
        end

        // Backpressure: consumer holds resp_ready low for five RESP cycles.
        rdy_mode = RDY_BACKPRESSURE;
        pend0.push_back(mk(16'h1111, 16'h2222, 3'b011));
        pend1.push_back(mk(16'h00F0, 16'h0003, 3'b101));
        drain("backpressure", 100);

        // No-op from requester 1, then the signed-overflow add.
        rdy_mode = RDY_ONE;
        base = id_log.size();
        pend1.push_back(mk(16'hBEEF, 16'h1234, 3'b111));
        drain("noop", 50);
        pend0.push_back(mk(16'h7FFF, 16'h0001, 3'b000));
        drain("overflow", 50);
        check("noop_owner", 32'(id_log.size() > base ? id_log[base] : 1'b0), 32'd1);

        // Reset while the request is in EXEC, then a tie.
        pend0.push_back(mk(16'h1234, 16'h0042, 3'b001));
        n = 0;
        do begin
            step();
            n++;
        end while (last_granted[0] !== 1'b1 && n < 50);
        check("exec_rst_grant", 32'(last_granted), 32'd1);
        pulse_reset();
        base = id_log.size();
        pend0.push_back(mk(16'h0100, 16'h0200, 3'b000));
        pend1.push_back(mk(16'h0300, 16'h0400, 3'b000));
        drain("post_reset", 50);
        check("post_reset_first", 32'(id_log.size() > base ? id_log[base] : 1'b1), 32'd0);

        // Randomised traffic with random arrivals and random consumer stalls.
        rdy_mode   = RDY_RANDOM;
        arrive_pct = 40;
        for (int i = 0; i < 120; i++) begin
            pend0.push_back(mk(W'($urandom), W'($urandom), 3'($urandom_range(7))));
            pend1.push_back(mk(W'($urandom), W'($urandom), 3'($urandom_range(7))));
        end
        drain("random", 8000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one `ALU_generalizado` instance between two independent requesters, for example the keypad calculator path and a serial command path. Each request carries two operands and an operation code. The block grants one requester at a time, registers the operands, executes on the shared ALU, and returns the result with the winner's ID over a valid/ready response handshake. It sits between the input-processing front ends and the single ALU, so neither front end drives the ALU directly.

## Interface
Parameters:
- `N_BITS`, 16, operand and result width; passed to `ALU_generalizado` as `n_bits`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  bit i high: requester i presents a request.
- `req_ready`  out  2  bit i high: request i accepted this cycle.
- `req0_a`, `req0_b`  in  N_BITS  operands of requester 0.
- `req1_a`, `req1_b`  in  N_BITS  operands of requester 1.
- `req0_op`, `req1_op`  in  3  operation code; 3'b111 means "no operation".
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer takes the response.
- `resp_id`  out  1  requester that owns the response.
- `resp_result`  out  N_BITS  ALU result.
- `resp_overflow`  out  1  ALU overflow flag.
- `resp_error`  out  1  high when the request carried op 3'b111; no ALU result in that case.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If any `req_valid` bit is high, the arbiter picks a winner g.
  - `req_ready[g]` is asserted combinationally in the same cycle.
  - On the clock edge, the block captures `a_r`, `b_r`, `op_r` and `id_r = g`, then moves to EXEC.
  - `req_ready` is 0 in every other state.
- **EXEC:**
  - The ALU is driven only from `a_r`, `b_r` and `op_r`.
  - On the edge, the block registers `resp_result` and `resp_overflow` from the ALU, then moves to RESP.
  - If `op_r == 3'b111`: result and overflow are registered as 0, `resp_error` is registered as 1, and the ALU output is ignored.
- **RESP:**
  - `resp_valid = 1`, and all `resp_*` outputs stay stable.
  - When `resp_ready` is high, the next state is IDLE. No new request is accepted in that same cycle.
- When idle, the ALU inputs are held at `a_r`/`b_r`. `op_r` keeps its last value; no forced default.
- **Widths:** result width is N_BITS. No truncation or extension is done in this block; overflow comes only from the ALU.
- **Arbitration:** see Configuration. A requester must hold `req_valid` and its operands stable until it sees `req_ready`. A `req_valid` that drops before grant is dropped silently.
- `last_grant` register: updated to g on every accept.

## Timing
- **Reset values:**
  - state = IDLE.
  - `req_ready` = 2'b00, `resp_valid` = 0, `resp_id` = 0, `resp_result` = 0, `resp_overflow` = 0, `resp_error` = 0, `busy` = 0.
  - `a_r` = `b_r` = 0, `op_r` = 3'b111, `last_grant` = 1 (so requester 0 wins the first tie).
- **Latency:**
  - Accept in cycle T.
  - `resp_valid` high from cycle T+2.
  - With `resp_ready` held high, the next accept is no earlier than T+3.
- **Simultaneous `req_valid = 2'b11`:** exactly one `req_ready` bit is high; never both.
- **Reset mid-operation (EXEC or RESP):** the in-flight request is discarded, no response is issued, and all outputs return to reset values on the next edge.
- **`resp_ready` high while `resp_valid` is low:** ignored.

## Configuration
- `ALU_ARB_ROUNDROBIN_EN` defined:
  - On a tie, the winner is the requester not equal to `last_grant`.
  - With a single valid requester, that requester wins.
- `ALU_ARB_ROUNDROBIN_EN` undefined:
  - Fixed priority; requester 0 always wins a tie.
  - `last_grant` is still maintained but not used.

## Test plan
- **Reset, then single request:** `rst` high for 2 cycles. Requester 0: a=16'h0003, b=16'h0004, op=3'b000. Required:
  - `req_ready` = 2'b01 in the same cycle.
  - `resp_valid` exactly 2 cycles later, `resp_id` = 0.
  - `resp_result`/`resp_overflow` equal the `ALU_generalizado` model output for those inputs.
  - `resp_error` = 0.
- **Simultaneous requests, held for 4 transactions, `resp_ready` = 1:**
  - With `ALU_ARB_ROUNDROBIN_EN`: `resp_id` sequence 0,1,0,1.
  - Without it: 0,0,0,0.
- **Response backpressure:** `resp_ready` = 0 for 5 cycles in RESP. Required:
  - `resp_valid` and all `resp_*` outputs stable.
  - `req_ready` = 0 throughout.
  - Accept resumes only after the handshake cycle.
- **No-op request:** requester 1, op=3'b111. Required: `resp_valid` with `resp_error` = 1, `resp_result` = 16'h0000, `resp_overflow` = 0, `resp_id` = 1.
- **Overflow case:** a=16'h7FFF, b=16'h0001, op = the ALU's add code. Required: `resp_overflow` matches the model (1), and `resp_result` matches the model.
- **Reset in EXEC:** assert `rst` one cycle after accept. Required:
  - No `resp_valid` at any point.
  - `busy` = 0 after the edge.
  - A subsequent request completes normally with `resp_id` = 0 priority on a tie.
